// File: rtl/fish_bite_reel_if.sv
// Control/status bundle between the fish engine and the game-flow logic.
interface fish_bite_reel_if;
  logic       tick;
  logic       cast_line;
  logic       reel_in;
  logic       q_start_menu;
  logic       q_base_play;
  logic       q_line_reel;
  logic       fish_hooked;
  logic       fish_caught_lost;
  logic       fish_caught;
  logic       line_out;
  logic [3:0] reel_progress;
  logic [3:0] tension;
  logic [7:0] catch_count;

  // Flow side: drives time base, player pulses and flow state.
  modport master (
    output tick, cast_line, reel_in, q_start_menu, q_base_play, q_line_reel,
    input  fish_hooked, fish_caught_lost, fish_caught, line_out, reel_progress, tension,
           catch_count
  );

  // Fish engine side.
  modport slave (
    input  tick, cast_line, reel_in, q_start_menu, q_base_play, q_line_reel,
    output fish_hooked, fish_caught_lost, fish_caught, line_out, reel_progress, tension,
           catch_count
  );
endinterface

// File: rtl/fish_bite_reel.sv
// Fish-side engine: random bite delay after a cast, reel/tension fight, catch tally.
module fish_bite_reel #(
  parameter logic [15:0] BITE_MIN    = 16'd20,
  parameter logic [15:0] BITE_MASK   = 16'h001F,
  parameter logic [3:0]  REEL_GOAL   = 4'd8,
  parameter logic [3:0]  TENSION_MAX = 4'd6,
  parameter logic [3:0]  SLACK_TICKS = 4'd10,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  fish_bite_reel_if.slave  bus
);

  localparam logic [15:0] SeedEff = (LFSR_SEED == 16'd0) ? 16'hACE1 : LFSR_SEED;

  typedef enum logic [1:0] {StIdle, StWaitBite, StReeling, StResult} state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d, bite_tmr_q, bite_load;
  logic [16:0] bite_sum;
  logic [3:0]  progress_q, tension_q, slack_q;
  logic [3:0]  prog_n, tens_n, slack_n;
  logic [4:0]  tens_sum, tens_diff;
  logic        hooked_q, cl_q, caught_q;
  logic [7:0]  count_q;
  logic        snap, catch_hit, escape, line_out;
  logic        enter_wait, enter_reel, enter_result, reel_keep;

  logic tick, cast_line, reel_in, q_start_menu, q_base_play, q_line_reel;
  assign tick         = bus.tick;
  assign cast_line    = bus.cast_line;
  assign reel_in      = bus.reel_in;
  assign q_start_menu = bus.q_start_menu;
  assign q_base_play  = bus.q_base_play;
  assign q_line_reel  = bus.q_line_reel;

  // Fight arithmetic and LFSR/bite-delay next values.
  always_comb begin
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    bite_sum  = {1'b0, BITE_MIN} + {1'b0, lfsr_q & BITE_MASK};
    bite_load = bite_sum[16] ? 16'hFFFF : bite_sum[15:0];
    prog_n    = (progress_q == 4'hF) ? 4'hF : progress_q + {3'b0, reel_in};
    tens_sum  = {1'b0, tension_q} + {4'b0, reel_in};
    tens_diff = tens_sum - {4'b0, tick};
    if (tens_sum < {4'b0, tick}) begin
      tens_n = 4'd0;
    end else if (tens_diff[4]) begin
      tens_n = 4'hF;
    end else begin
      tens_n = tens_diff[3:0];
    end
    if (tens_n != 4'd0) begin
      slack_n = 4'd0;
    end else if (tick) begin
      slack_n = (slack_q == 4'hF) ? 4'hF : slack_q + 4'd1;
    end else begin
      slack_n = slack_q;
    end
    snap      = tens_n > TENSION_MAX;
    catch_hit = prog_n == REEL_GOAL;
    escape    = slack_n == SLACK_TICKS;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the start menu overrides everything.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cast_line && q_base_play) state_d = StWaitBite;
      end
      StWaitBite: begin
        if (reel_in || !q_base_play) begin
          state_d = StIdle;
        end else if (tick && bite_tmr_q == 16'd0) begin
          state_d = StReeling;
        end
      end
      StReeling: begin
        // Flow FSM sees the hook one edge late, so ignore q_line_reel while hooked_q is high.
        if (!hooked_q && !q_line_reel) begin
          state_d = StIdle;
        end else if (snap || catch_hit || escape) begin
          state_d = StResult;
        end
      end
      StResult: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (q_start_menu) state_d = StIdle;
  end

  // Decoded outputs and transition strobes.
  always_comb begin
    line_out     = (state_q == StWaitBite) || (state_q == StReeling);
    enter_wait   = (state_q == StIdle) && (state_d == StWaitBite);
    enter_reel   = (state_q == StWaitBite) && (state_d == StReeling);
    enter_result = (state_q == StReeling) && (state_d == StResult);
    reel_keep    = (state_q == StReeling) && ((state_d == StReeling) || (state_d == StResult));
  end

  // Datapath: LFSR, bite timer, fight counters, pulses and tally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q     <= SeedEff;
      bite_tmr_q <= 16'd0;
      progress_q <= 4'd0;
      tension_q  <= 4'd0;
      slack_q    <= 4'd0;
      hooked_q   <= 1'b0;
      cl_q       <= 1'b0;
      caught_q   <= 1'b0;
      count_q    <= 8'd0;
    end else begin
      lfsr_q   <= lfsr_d;
      hooked_q <= enter_reel;
      cl_q     <= enter_result;
      if (enter_wait) begin
        bite_tmr_q <= bite_load;
      end else if ((state_q == StWaitBite) && tick && (bite_tmr_q != 16'd0)) begin
        bite_tmr_q <= bite_tmr_q - 16'd1;
      end
      // Final fight values stay visible through the result cycle, then clear.
      if (reel_keep) begin
        progress_q <= prog_n;
        tension_q  <= tens_n;
        slack_q    <= slack_n;
      end else begin
        progress_q <= 4'd0;
        tension_q  <= 4'd0;
        slack_q    <= 4'd0;
      end
      if (enter_reel) begin
        caught_q <= 1'b0;
      end else if (enter_result) begin
        caught_q <= catch_hit && !snap;
      end
      if (q_start_menu) begin
        count_q <= 8'd0;
      end else if (enter_result && catch_hit && !snap && (count_q != 8'hFF)) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  assign bus.fish_hooked      = hooked_q;
  assign bus.fish_caught_lost = cl_q;
  assign bus.fish_caught      = caught_q;
  assign bus.line_out         = line_out;
  assign bus.reel_progress    = progress_q;
  assign bus.tension          = tension_q;
  assign bus.catch_count      = count_q;

endmodule

// File: tb/tb_fish_bite_reel.sv
// Bench for fish_bite_reel: reel-fight vector table plus hand sequences for bite/abort/reset.
module tb_fish_bite_reel;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fish_bite_reel_if bus();

  fish_bite_reel dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int hook_cnt = 0;
  int cl_cnt = 0;
  logic [15:0] m_lfsr;

  // Reference LFSR: Fibonacci, taps 16,14,13,11, one step per clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  typedef struct {
    bit         rehook;
    bit         reel;
    bit         tick;
    bit         exp_cl;
    bit         exp_caught;
    logic [3:0] exp_prog;
    logic [3:0] exp_tens;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit rehook, bit reel, bit tick, bit cl, bit caught, int prog,
                              int tens, int cnt);
    vec_t v;
    v.rehook = rehook; v.reel = reel; v.tick = tick; v.exp_cl = cl; v.exp_caught = caught;
    v.exp_prog = 4'(prog); v.exp_tens = 4'(tens); v.exp_cnt = 8'(cnt);
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.fish_hooked === 1'b1) hook_cnt++;
    if (bus.fish_caught_lost === 1'b1) cl_cnt++;
  endtask

  // Cast from IDLE, tick every gap cycles; hook must land on tick L+1.
  task automatic hook(input string tag, input int gap);
    int l_exp;
    int got;
    got = 0;
    bus.q_base_play = 1'b1;
    bus.q_line_reel = 1'b1;
    bus.cast_line = 1'b1;
    l_exp = 20 + int'(m_lfsr & 16'h001F);
    step();
    bus.cast_line = 1'b0;
    chk({tag, " line_out after cast"}, 32'(bus.line_out), 1);
    for (int t = 1; t <= 80 && got == 0; t++) begin
      repeat (gap - 1) step();
      bus.tick = 1'b1;
      step();
      bus.tick = 1'b0;
      if (bus.fish_hooked === 1'b1) got = t;
    end
    chk({tag, " hook tick"}, got, l_exp + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hc0;
    int cc0;
    bus.tick = 1'b0; bus.cast_line = 1'b0; bus.reel_in = 1'b0;
    bus.q_start_menu = 1'b0; bus.q_base_play = 1'b0; bus.q_line_reel = 1'b0;

    // Catch: 8 rounds of reel+tick
    for (int k = 1; k <= 8; k++) add(k == 1, 1, 1, k == 8, k == 8, k, 0, (k == 8) ? 1 : 0);
    add(0, 0, 0, 0, 1, 0, 0, 1);
    // Snap: 7 reels, no tick
    for (int k = 1; k <= 7; k++) add(k == 1, 1, 0, k == 7, 0, k, k, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // Escape: 10 slack ticks
    for (int k = 1; k <= 10; k++) add(k == 1, 0, 1, k == 10, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // Escape delayed: a reel after 8 slack ticks restarts the slack count
    for (int k = 1; k <= 8; k++) add(k == 1, 0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1, 1, 1);
    for (int k = 1; k <= 10; k++) add(0, 0, 1, k == 10, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);

    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk("reset line_out", 32'(bus.line_out), 0);
    chk("reset hooked", 32'(bus.fish_hooked), 0);
    chk("reset caught_lost", 32'(bus.fish_caught_lost), 0);
    chk("reset caught", 32'(bus.fish_caught), 0);
    chk("reset progress", 32'(bus.reel_progress), 0);
    chk("reset tension", 32'(bus.tension), 0);
    chk("reset count", 32'(bus.catch_count), 0);

    // Cast ignored outside base play
    bus.cast_line = 1'b1;
    step();
    bus.cast_line = 1'b0;
    chk("cast w/o base_play", 32'(bus.line_out), 0);

    // Bite with tick every 4 clocks, single hook pulse
    hc0 = hook_cnt;
    hook("bite4", 4);
    repeat (3) step();
    chk("bite4 single pulse", hook_cnt - hc0, 1);
    chk("bite4 still reeling", 32'(bus.line_out), 1);

    // q_line_reel drop mid-fight: IDLE, no result pulse
    cc0 = cl_cnt;
    bus.q_line_reel = 1'b0;
    step();
    chk("abort line_out", 32'(bus.line_out), 0);
    repeat (2) step();
    chk("abort no result pulse", cl_cnt - cc0, 0);

    // Abort ignored in the hook cycle, taken on the next
    hook("hookabort", 1);
    bus.q_line_reel = 1'b0;
    step();
    chk("abort skipped while hooked", 32'(bus.line_out), 1);
    step();
    chk("abort after hook cycle", 32'(bus.line_out), 0);
    bus.q_line_reel = 1'b1;

    // Async reset during a fight with tension 3
    hook("rst", 1);
    bus.reel_in = 1'b1;
    repeat (3) step();
    bus.reel_in = 1'b0;
    chk("pre-reset tension", 32'(bus.tension), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst line_out", 32'(bus.line_out), 0);
    chk("async rst tension", 32'(bus.tension), 0);
    chk("async rst progress", 32'(bus.reel_progress), 0);
    chk("async rst hooked", 32'(bus.fish_hooked), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("lfsr after release", 32'(dut.lfsr_q), 32'h0000ACE1);
    cc0 = cl_cnt;
    repeat (3) step();
    chk("no pulse after reset", cl_cnt - cc0, 0);

    // Reel-fight table
    foreach (vecs[i]) begin
      if (vecs[i].rehook) hook($sformatf("row%0d", i), 1);
      bus.reel_in = vecs[i].reel;
      bus.tick = vecs[i].tick;
      step();
      bus.reel_in = 1'b0;
      bus.tick = 1'b0;
      chk($sformatf("row%0d caught_lost", i), 32'(bus.fish_caught_lost), 32'(vecs[i].exp_cl));
      chk($sformatf("row%0d caught", i), 32'(bus.fish_caught), 32'(vecs[i].exp_caught));
      chk($sformatf("row%0d progress", i), 32'(bus.reel_progress), 32'(vecs[i].exp_prog));
      chk($sformatf("row%0d tension", i), 32'(bus.tension), 32'(vecs[i].exp_tens));
      chk($sformatf("row%0d count", i), 32'(bus.catch_count), 32'(vecs[i].exp_cnt));
    end

    // reel_in during WAIT_BITE cancels; no hook afterwards
    bus.cast_line = 1'b1;
    step();
    bus.cast_line = 1'b0;
    chk("wait line_out", 32'(bus.line_out), 1);
    bus.reel_in = 1'b1;
    step();
    bus.reel_in = 1'b0;
    chk("reel cancels wait", 32'(bus.line_out), 0);
    hc0 = hook_cnt;
    bus.tick = 1'b1;
    repeat (60) step();
    bus.tick = 1'b0;
    chk("no hook after cancel", hook_cnt - hc0, 0);

    // Leaving base play cancels the wait
    bus.cast_line = 1'b1;
    step();
    bus.cast_line = 1'b0;
    bus.q_base_play = 1'b0;
    step();
    chk("base_play drop cancels", 32'(bus.line_out), 0);
    bus.q_base_play = 1'b1;

    // Cast beats reel in IDLE, then start menu clears the tally
    bus.cast_line = 1'b1;
    bus.reel_in = 1'b1;
    step();
    bus.cast_line = 1'b0;
    bus.reel_in = 1'b0;
    chk("cast wins over reel", 32'(bus.line_out), 1);
    bus.q_start_menu = 1'b1;
    step();
    bus.q_start_menu = 1'b0;
    chk("menu forces idle", 32'(bus.line_out), 0);
    chk("menu clears count", 32'(bus.catch_count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
